// File: rtl/tb_uart_rx_if.sv
// Receive byte stream between the UART receiver and its consumer.
// The master side sources data/valid and the slave side returns ready.
interface tb_uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/tb_uart_rx.sv
// 8N1 UART receiver with a small byte FIFO and advisory RTS flow control.
// Start, data and stop bits are sampled mid-bit from the synchronized line.
module tb_uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic         clk_uart,
    input  logic         clk_uart_rst_n,
    input  logic         i_uart_rxd,
    output logic         o_uart_rts_n,
    output logic         o_framing_err,
    output logic         o_overflow,
    tb_uart_rx_if.master rx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, BREAK
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shr, shr_n;
    logic          sync1, rxd_s;
    logic          push, ferr;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr, rd, rd_n;
    logic [AW:0]   count, count_n;
    logic [7:0]    data_q, data_n;
    logic          pop, full, wr_en, ovf;

    always_ff @(posedge clk_uart or negedge clk_uart_rst_n) begin
        if (!clk_uart_rst_n) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= i_uart_rxd;
            rxd_s <= sync1;
        end
    end

    always_ff @(posedge clk_uart or negedge clk_uart_rst_n) begin
        if (!clk_uart_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shr   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shr   <= shr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shr_n   = shr;
        push    = 1'b0;
        ferr    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_n = START;
                    cnt_n   = CW'(CLKS_PER_BIT / 2 - 1);
                end
            end
            START: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (!rxd_s) begin
                    state_n = DATA;
                    cnt_n   = CW'(CLKS_PER_BIT - 1);
                    idx_n   = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            DATA: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    shr_n = {rxd_s, shr[7:1]};
                    cnt_n = CW'(CLKS_PER_BIT - 1);
                    idx_n = idx + 1'b1;
                    if (idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (rxd_s) begin
                    push    = 1'b1;
                    state_n = IDLE;
                end else begin
                    ferr    = 1'b1;
                    state_n = BREAK;
                end
            end
            BREAK: begin
                if (rxd_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign pop   = rx.valid & rx.ready;
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign wr_en = push & (~full | pop);
    assign ovf   = push & full & ~pop;

    always_comb begin
        count_n = count + (AW+1)'(wr_en) - (AW+1)'(pop);
        rd_n    = pop ? rd + 1'b1 : rd;
        data_n  = data_q;
        // Bypass the array when the pushed byte becomes the new head.
        if (count_n != '0) begin
            if (wr_en && wr == rd_n) data_n = shr;
            else                     data_n = mem[rd_n];
        end
    end

    always_ff @(posedge clk_uart) begin
        if (wr_en) mem[wr] <= shr;
    end

    always_ff @(posedge clk_uart or negedge clk_uart_rst_n) begin
        if (!clk_uart_rst_n) begin
            wr            <= '0;
            rd            <= '0;
            count         <= '0;
            data_q        <= '0;
            o_uart_rts_n  <= 1'b0;
            o_framing_err <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            if (wr_en) wr <= wr + 1'b1;
            rd            <= rd_n;
            count         <= count_n;
            data_q        <= data_n;
            o_uart_rts_n  <= (count_n >= (AW+1)'(FIFO_DEPTH - 1));
            o_framing_err <= ferr;
            o_overflow    <= ovf;
        end
    end

    assign rx.data  = data_q;
    assign rx.valid = (count != '0);

endmodule
